// File: rtl/simon_block_cipher_core_if.sv
// simon_block_cipher_core_if: block/result handshake and round-key read port of the Simon core
interface simon_block_cipher_core_if #(
  parameter int WORD_W     = 64,
  parameter int KEY_ADDR_W = 9
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [2*WORD_W-1:0]     in_data;
  logic                    in_decrypt;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*WORD_W-1:0]     out_data;
  logic                    key_rd_en;
  logic [KEY_ADDR_W-1:0]   key_addr;
  logic [WORD_W-1:0]       key_data;
  logic                    busy;
  modport master (
    output in_valid, in_data, in_decrypt, out_ready, key_data,
    input  in_ready, out_valid, out_data, key_rd_en, key_addr, busy
  );
  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready, key_data,
    output in_ready, out_valid, out_data, key_rd_en, key_addr, busy
  );
endinterface

// File: rtl/simon_block_cipher_core.sv
// simon_block_cipher_core: iterative Simon encrypt/decrypt, one round per cycle, keys streamed from an external memory
module simon_block_cipher_core #(
  parameter int WORD_W     = 64,
  parameter int ROUNDS     = 72,
  parameter int KEY_ADDR_W = 9,
  parameter int KEY_LAT    = 1
) (
  input logic clk,
  input logic rst,
  simon_block_cipher_core_if.slave bus
);
  localparam int CW = $clog2(ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, PRIME, ROUND, DONE} state_t;
  state_t              state_q, state_d;
  logic [WORD_W-1:0]   x_q, x_d, y_q, y_d, f, rnd;
  logic [2*WORD_W-1:0] out_q, out_d;
  logic                dec_q, dec_d;
  logic [CW-1:0]       rc_q, rc_d, rd_q, rd_d;
  logic [1:0]          pc_q, pc_d;
  logic                rd_en;
  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int r);
    return (v << r) | (v >> (WORD_W - r));
  endfunction
  assign f     = (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2);
  assign rnd   = y_q ^ f ^ bus.key_data;
  // reads run KEY_LAT ahead of the rounds and stop once every key has been requested
  assign rd_en = (state_q == PRIME || state_q == ROUND) && rd_q < CW'(ROUNDS);
  assign bus.key_rd_en = rd_en;
  assign bus.key_addr  = rd_en ? (dec_q ? KEY_ADDR_W'(ROUNDS - 1) - KEY_ADDR_W'(rd_q) : KEY_ADDR_W'(rd_q)) : '0;
  assign bus.in_ready  = state_q == IDLE && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = out_q;
  assign bus.busy      = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dec_d   = dec_q;
    rc_d    = rc_q;
    pc_d    = pc_q;
    out_d   = out_q;
    rd_d    = rd_q + CW'(rd_en);
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = PRIME;
        dec_d   = bus.in_decrypt;
        x_d     = bus.in_decrypt ? bus.in_data[WORD_W-1:0] : bus.in_data[2*WORD_W-1:WORD_W];
        y_d     = bus.in_decrypt ? bus.in_data[2*WORD_W-1:WORD_W] : bus.in_data[WORD_W-1:0];
        rc_d    = '0;
        pc_d    = '0;
        rd_d    = '0;
      end
      PRIME: begin
        pc_d    = pc_q + 2'd1;
        state_d = pc_q == 2'(KEY_LAT - 1) ? ROUND : PRIME;
      end
      ROUND: begin
        x_d  = rnd;
        y_d  = x_q;
        rc_d = rc_q + CW'(1);
        if (rc_q == CW'(ROUNDS - 1)) begin
          state_d = DONE;
          out_d   = dec_q ? {x_q, rnd} : {rnd, x_q};
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dec_q   <= 1'b0;
      rc_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dec_q   <= dec_d;
      rc_q    <= rc_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: doc/simon_block_cipher_core.md
SIMON_BLOCK_CIPHER_CORE -- requirements
Module: simon_block_cipher_core

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning the Simon word size n; legal values are 16, 24, 32, 48 and 64; the block is 2*WORD_W bits.
REQ-002 SHALL have parameter ROUNDS, default 72, meaning the round count T; the legal range is 1..2**KEY_ADDR_W.
REQ-003 SHALL have parameter KEY_ADDR_W, default 9, meaning the round-key address width.
REQ-004 SHALL have parameter KEY_LAT, default 1, meaning the key-memory read latency in cycles; the legal range is 1..4.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input block valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the core accepts a block.
REQ-009 SHALL have port in_data, input, 2*WORD_W bits: input block, {x (upper), y (lower)}.
REQ-010 SHALL have port in_decrypt, input, 1 bit: mode, sampled at accept; 1 means decrypt.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_data, output, 2*WORD_W bits: result block, {x, y}.
REQ-014 SHALL have port key_rd_en, output, 1 bit: round-key read strobe.
REQ-015 SHALL have port key_addr, output, KEY_ADDR_W bits: round-key index.
REQ-016 SHALL have port key_data, input, WORD_W bits: round key, valid KEY_LAT cycles after the matching key_rd_en.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement the round function f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x), with all rotations modulo WORD_W.
REQ-019 SHALL update each round as x <= y ^ f(x) ^ k[i] and y <= x.
REQ-020 SHALL, when encrypting, load x = in_data upper and y = in_data lower, use keys in the order i = 0..ROUNDS-1, and output {x, y}.
REQ-021 SHALL, when decrypting, load x = in_data lower and y = in_data upper, use keys in the order i = ROUNDS-1..0, and output {y, x}, so that decrypt(encrypt(P)) = P.
REQ-022 SHALL implement an FSM with the states IDLE, PRIME, ROUND and DONE.
REQ-023 SHALL, in IDLE, drive in_ready = 1; on in_valid & in_ready, capture in_data and in_decrypt and move to PRIME.
REQ-024 SHALL drive in_ready = 0 in every state other than IDLE; no acceptance takes place in the cycle DONE exits.
REQ-025 SHALL, in PRIME, stay for exactly KEY_LAT cycles issuing the first KEY_LAT key reads, then move to ROUND.
REQ-026 SHALL, in ROUND, perform exactly one round per cycle for ROUNDS cycles, consuming key_data in issue order.
REQ-027 SHALL keep reads running ahead by KEY_LAT and SHALL issue exactly ROUNDS reads per block, with key_rd_en = 0 once all reads are issued.
REQ-028 SHALL drive key_addr as 0,1,...,ROUNDS-1 for encrypt and ROUNDS-1,...,0 for decrypt, zero-extended; key_addr is don't-care while key_rd_en = 0.
REQ-029 SHALL, after the last round, register out_data and move to DONE with out_valid = 1.
REQ-030 SHALL give a latency of KEY_LAT + ROUNDS + 1 cycles from the accept edge to the first cycle out_valid is high.
REQ-031 SHALL, in DONE, hold out_valid and out_data stable until out_valid & out_ready, then return to IDLE; back-pressure may last indefinitely.
REQ-032 SHALL, for ROUNDS = 1, pass through PRIME and a single ROUND cycle with no special case.
REQ-033 SHALL let in_data and in_decrypt changing after accept have no effect on the block in flight.
REQ-034 SHALL keep the round counter $clog2(ROUNDS+1) bits wide and SHALL NOT let it wrap within a block.

Reset
REQ-035 SHALL, on rst, set the state to IDLE, in_ready = 0 during rst and 1 in the cycle after, and out_valid = 0, key_rd_en = 0, busy = 0, out_data = 0, key_addr = 0.
REQ-036 SHALL, on rst asserted mid-operation (PRIME, ROUND or DONE), abort and discard the block, produce no out_valid, and ignore key_data still in flight.

Verification
REQ-037 SHALL pass Simon128/256 (WORD_W=64, ROUNDS=72, key memory preloaded by the bench's key-expansion model, key 1f1e...0100): encrypt of 74206e69206d6f6f6d69732061207369 -> 8d2b5579afc8a3a03bf72a87efe7b868, with out_valid exactly 74 cycles after accept at KEY_LAT=1.
REQ-038 SHALL pass Simon32/64 (WORD_W=16, ROUNDS=32, key 1918111009080100): encrypt of 65656877 -> c69be9bb, and decrypt of c69be9bb -> 65656877, with the key_addr sequence 31 down to 0 on decrypt.
REQ-039 SHALL pass a KEY_LAT sweep 1..4 with the 128/256 vector: same ciphertext; latency = KEY_LAT+73; exactly 72 key_rd_en pulses per block.
REQ-040 SHALL pass back-pressure: out_ready held 0 for 20 cycles -> out_valid and out_data stable, in_ready = 0 throughout; the next block is accepted no earlier than the cycle after the output handshake.
REQ-041 SHALL pass reset mid-ROUND: rst at round 30 -> out_valid never asserted, in_ready = 1 the cycle after rst drops, and the next vector is correct.
REQ-042 SHALL pass random round-trip: 1000 random blocks and modes against the reference model, including consecutive encrypt/decrypt pairs returning the plaintext.
